// File: rtl/imsic_setipnum_arbiter.sv
// imsic_setipnum_arbiter: round-robin arbiter that shares the IMSIC setipnum write port
// among NrReq requesters. Requests are checked for hart, file and identity range. Valid
// requests are queued in a small FIFO, and that FIFO drains one write per cycle to the
// interrupt files. Invalid requests are accepted, discarded and counted.
// Optional feature: define IMSIC_SETIP_DEDUP_EN to absorb requests whose (hart,file,id)
// already sits in the FIFO.
module imsic_setipnum_arbiter #(
   parameter int unsigned NrReq     = 2,
   parameter int unsigned NrHarts   = 4,
   parameter int unsigned NrFiles   = 2,
   parameter int unsigned NrIds     = 64,
   parameter int unsigned FifoDepth = 4,
   localparam int unsigned HartW    = (NrHarts > 1) ? $clog2(NrHarts) : 1,
   localparam int unsigned FileW    = (NrFiles > 1) ? $clog2(NrFiles) : 1,
   localparam int unsigned IdW      = $clog2(NrIds),
   localparam int unsigned LvlW     = $clog2(FifoDepth + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NrReq-1:0]       i_req_valid,
   output logic [NrReq-1:0]       o_req_ready,
   input  logic [NrReq*HartW-1:0] i_req_hart,
   input  logic [NrReq*FileW-1:0] i_req_file,
   input  logic [NrReq*IdW-1:0]   i_req_id,
   output logic                   o_setip_valid,
   input  logic                   i_setip_ready,
   output logic [HartW-1:0]       o_setip_hart,
   output logic [FileW-1:0]       o_setip_file,
   output logic [IdW-1:0]         o_setip_id,
   output logic [LvlW-1:0]        o_fifo_level,
   output logic [15:0]            o_drop_cnt
);

   localparam int unsigned ReqW = (NrReq > 1) ? $clog2(NrReq) : 1;
   localparam int unsigned PtrW = $clog2(FifoDepth);

   // FIFO storage, indexed by the read and write pointers
   logic [HartW-1:0] hart_q [FifoDepth];
   logic [FileW-1:0] file_q [FifoDepth];
   logic [IdW-1:0]   id_q   [FifoDepth];

   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LvlW-1:0] level_q, level_d;
   logic [15:0]     drop_cnt_q, drop_cnt_d;
   logic [ReqW-1:0] prio_q, prio_d;

   logic            grant_any;
   logic [ReqW-1:0] grant_idx;
   logic [ReqW-1:0] cand;
   logic [HartW-1:0] g_hart;
   logic [FileW-1:0] g_file;
   logic [IdW-1:0]   g_id;
   logic g_invalid, g_dup, pop, room, accept, push;

   // Round-robin search starting at the current highest-priority requester
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = prio_q;
      for (int i = 0; i < NrReq; i++) begin
         if (!grant_any && i_req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
         cand = (32'(cand) == NrReq - 1) ? '0 : cand + ReqW'(1);
      end
   end

   // Select the granted requester's payload
   always_comb begin
      g_hart = '0;
      g_file = '0;
      g_id   = '0;
      for (int r = 0; r < NrReq; r++) begin
         if (grant_idx == ReqW'(r)) begin
            g_hart = i_req_hart[r*HartW +: HartW];
            g_file = i_req_file[r*FileW +: FileW];
            g_id   = i_req_id[r*IdW +: IdW];
         end
      end
   end

   assign g_invalid = (32'(g_hart) >= NrHarts) || (32'(g_file) >= NrFiles) ||
                      (g_id == '0) || (32'(g_id) >= NrIds);

`ifdef IMSIC_SETIP_DEDUP_EN
   // Match against every occupied entry, including a head that pops this cycle
   always_comb begin
      g_dup = 1'b0;
      for (int k = 0; k < FifoDepth; k++) begin
         if ((32'(PtrW'(PtrW'(k) - rd_ptr_q)) < 32'(level_q)) &&
             (hart_q[k] == g_hart) && (file_q[k] == g_file) && (id_q[k] == g_id)) begin
            g_dup = 1'b1;
         end
      end
   end
`else
   assign g_dup = 1'b0;
`endif

   assign pop    = (level_q != '0) && i_setip_ready;
   assign room   = (32'(level_q) < FifoDepth) || pop;
   // Invalid and duplicate requests never need space, so they are accepted even when full
   assign accept = grant_any && (g_invalid || g_dup || room);
   assign push   = accept && !g_invalid && !g_dup;

   // One-hot ready for the accepted requester
   always_comb begin
      o_req_ready = '0;
      for (int r = 0; r < NrReq; r++) begin
         o_req_ready[r] = accept && (grant_idx == ReqW'(r));
      end
   end

   assign o_setip_valid = (level_q != '0);
   assign o_setip_hart  = hart_q[rd_ptr_q];
   assign o_setip_file  = file_q[rd_ptr_q];
   assign o_setip_id    = id_q[rd_ptr_q];
   assign o_fifo_level  = level_q;
   assign o_drop_cnt    = drop_cnt_q;

   // Next-state for pointers, level, drop counter and round-robin priority
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      level_d    = level_q;
      drop_cnt_d = drop_cnt_q;
      prio_d     = prio_q;
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      level_d = level_q + LvlW'(1);
      else if (pop && !push) level_d = level_q - LvlW'(1);
      if (accept && g_invalid && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
      if (accept) prio_d = (32'(grant_idx) == NrReq - 1) ? '0 : grant_idx + ReqW'(1);
   end

   // State registers and FIFO writes, synchronous reset clears everything queued
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < FifoDepth; k++) begin
            hart_q[k] <= '0;
            file_q[k] <= '0;
            id_q[k]   <= '0;
         end
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         drop_cnt_q <= '0;
         prio_q     <= '0;
      end else begin
         if (push) begin
            hart_q[wr_ptr_q] <= g_hart;
            file_q[wr_ptr_q] <= g_file;
            id_q[wr_ptr_q]   <= g_id;
         end
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         level_q    <= level_d;
         drop_cnt_q <= drop_cnt_d;
         prio_q     <= prio_d;
      end
   end

endmodule

// File: tb/tb_imsic_setipnum_arbiter.sv
// Bench for imsic_setipnum_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a queue-based reference model. Honours IMSIC_SETIP_DEDUP_EN.
module tb_imsic_setipnum_arbiter;

   localparam int unsigned NrReq     = 2;
   localparam int unsigned NrHarts   = 3;
   localparam int unsigned NrFiles   = 3;
   localparam int unsigned NrIds     = 48;
   localparam int unsigned FifoDepth = 4;
   localparam int unsigned HartW     = 2;
   localparam int unsigned FileW     = 2;
   localparam int unsigned IdW       = 6;
   localparam int unsigned LvlW      = 3;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NrReq-1:0]       req_valid;
   logic [NrReq-1:0]       req_ready;
   logic [NrReq*HartW-1:0] req_hart;
   logic [NrReq*FileW-1:0] req_file;
   logic [NrReq*IdW-1:0]   req_id;
   logic                   setip_valid;
   logic                   setip_ready;
   logic [HartW-1:0]       setip_hart;
   logic [FileW-1:0]       setip_file;
   logic [IdW-1:0]         setip_id;
   logic [LvlW-1:0]        fifo_level;
   logic [15:0]            drop_cnt;

   imsic_setipnum_arbiter #(
      .NrReq(NrReq), .NrHarts(NrHarts), .NrFiles(NrFiles), .NrIds(NrIds), .FifoDepth(FifoDepth)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_hart(req_hart), .i_req_file(req_file), .i_req_id(req_id),
      .o_setip_valid(setip_valid), .i_setip_ready(setip_ready),
      .o_setip_hart(setip_hart), .o_setip_file(setip_file), .o_setip_id(setip_id),
      .o_fifo_level(fifo_level), .o_drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {int hart; int file; int id;} ent_t;

   ent_t q[$];
   int   drop_m = 0;
   int   last_m = NrReq - 1;
   int   pops_m = 0;
   int   checks = 0;
   int   errors = 0;
   int   r_hart[NrReq];
   int   r_file[NrReq];
   int   r_id[NrReq];
   logic [NrReq-1:0] acc_vec;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input int h, input int f, input int id);
      r_hart[r] = h;
      r_file[r] = f;
      r_id[r]   = id;
      req_valid[r] = 1'b1;
   endtask

   // One clock: compare at negedge against the model, then advance the model at posedge
   task automatic step();
      int g;
      int h;
      int f;
      int id;
      bit inv;
      bit dup;
      bit pop;
      bit acc;
      logic [NrReq-1:0] exp_ready;
      g = -1; h = 0; f = 0; id = 0;
      inv = 1'b0; dup = 1'b0; pop = 1'b0; acc = 1'b0;
      exp_ready = '0;
      for (int r = 0; r < NrReq; r++) begin
         req_hart[r*HartW +: HartW] = HartW'(r_hart[r]);
         req_file[r*FileW +: FileW] = FileW'(r_file[r]);
         req_id[r*IdW +: IdW]       = IdW'(r_id[r]);
      end
      @(negedge clk);
      if (!rst) begin
         check("level", 32'(fifo_level), q.size());
         check("drop_cnt", 32'(drop_cnt), drop_m);
         check("setip_valid", 32'(setip_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            check("setip_hart", 32'(setip_hart), q[0].hart);
            check("setip_file", 32'(setip_file), q[0].file);
            check("setip_id", 32'(setip_id), q[0].id);
         end
         for (int k = 0; k < NrReq; k++) begin
            int r;
            r = (last_m + 1 + k) % NrReq;
            if (g < 0 && req_valid[r]) g = r;
         end
         pop = (q.size() != 0) && setip_ready;
         if (g >= 0) begin
            h = r_hart[g]; f = r_file[g]; id = r_id[g];
            inv = (h >= NrHarts) || (f >= NrFiles) || (id == 0) || (id >= NrIds);
`ifdef IMSIC_SETIP_DEDUP_EN
            if (!inv) foreach (q[k]) if (q[k].hart == h && q[k].file == f && q[k].id == id) dup = 1'b1;
`endif
            acc = inv || dup || (q.size() < FifoDepth) || pop;
            if (acc) exp_ready[g] = 1'b1;
         end
         check("req_ready", 32'(req_ready), 32'(exp_ready));
      end
      acc_vec = exp_ready;
      @(posedge clk);
      if (rst) begin
         q.delete();
         drop_m = 0;
         last_m = NrReq - 1;
         acc_vec = '0;
      end else begin
         if (pop) begin
            void'(q.pop_front());
            pops_m++;
         end
         if (acc) begin
            last_m = g;
            if (inv) drop_m = (drop_m == 65535) ? 65535 : drop_m + 1;
            else if (!dup) q.push_back('{hart: h, file: f, id: id});
         end
      end
      #1;
   endtask

   initial begin
      logic [NrReq-1:0] grants[4];
      int seen[$];
      int pops_before;

      rst = 1'b1;
      req_valid = '0;
      setip_ready = 1'b0;
      for (int r = 0; r < NrReq; r++) begin
         r_hart[r] = 0; r_file[r] = 0; r_id[r] = 0;
      end
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst_valid", 32'(setip_valid), 0);
      check("rst_hart", 32'(setip_hart), 0);
      check("rst_file", 32'(setip_file), 0);
      check("rst_id", 32'(setip_id), 0);
      check("rst_level", 32'(fifo_level), 0);
      check("rst_drop", 32'(drop_cnt), 0);
      check("rst_ready", 32'(req_ready), 0);
      step();

      // Both requesters continuously valid: grants alternate starting with requester 0
      setip_ready = 1'b1;
      set_req(0, 0, 0, 1);
      set_req(1, 1, 1, 2);
      for (int n = 0; n < 4; n++) begin
         step();
         grants[n] = acc_vec;
         if (n == 0) check("first_out_id", 32'(setip_id), 1);
         for (int r = 0; r < NrReq; r++) if (acc_vec[r]) r_id[r] = r_id[r] + 2;
      end
      check("rr_grant0", 32'(grants[0]), 32'h1);
      check("rr_grant1", 32'(grants[1]), 32'h2);
      check("rr_grant2", 32'(grants[2]), 32'h1);
      check("rr_grant3", 32'(grants[3]), 32'h2);
      req_valid = '0;
      for (int n = 0; n < 6; n++) step();

      // Fill with ids 1..4 while blocked, 5th must wait, then drain in order
      setip_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         set_req(0, 0, 0, i);
         step();
      end
      check("full_block", 32'(acc_vec), 0);
      check("full_level", 32'(fifo_level), 4);
      setip_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         if (setip_valid) seen.push_back(int'(setip_id));
         step();
         if (acc_vec[0]) req_valid[0] = 1'b0;
      end
      check("drain_count", seen.size(), 5);
      for (int i = 0; i < 5 && i < seen.size(); i++) check("drain_order", seen[i], i + 1);

      // Invalid requests while full: accepted, dropped, level unchanged
      setip_ready = 1'b0;
      for (int i = 10; i < 14; i++) begin
         set_req(0, 0, 1, i);
         step();
      end
      set_req(0, 3, 0, 5);
      step();
      check("bad_hart_acc", 32'(acc_vec), 32'h1);
      set_req(0, 0, 3, 5);
      step();
      check("bad_file_acc", 32'(acc_vec), 32'h1);
      set_req(0, 0, 0, 0);
      step();
      check("bad_id_acc", 32'(acc_vec), 32'h1);
      req_valid = '0;
      check("drop_three", 32'(drop_cnt), 3);
      check("drop_level", 32'(fifo_level), 4);

      // Full with simultaneous pop and push
      setip_ready = 1'b1;
      set_req(0, 2, 2, 20);
      step();
      check("full_pushpop_acc", 32'(acc_vec), 32'h1);
      check("full_pushpop_level", 32'(fifo_level), 4);
      req_valid = '0;
      for (int n = 0; n < 6; n++) step();

      // Duplicate (1,1,5) while the first copy is still queued
      setip_ready = 1'b0;
      set_req(0, 1, 1, 5);
      step();
      step();
      check("dup_acc", 32'(acc_vec), 32'h1);
      req_valid = '0;
`ifdef IMSIC_SETIP_DEDUP_EN
      check("dup_level", 32'(fifo_level), 1);
`else
      check("dup_level", 32'(fifo_level), 2);
`endif
      pops_before = pops_m;
      setip_ready = 1'b1;
      for (int n = 0; n < 4; n++) step();
`ifdef IMSIC_SETIP_DEDUP_EN
      check("dup_writes", pops_m - pops_before, 1);
`else
      check("dup_writes", pops_m - pops_before, 2);
`endif

      // Random traffic; requesters hold payload until accepted
      for (int n = 0; n < 800; n++) begin
         for (int r = 0; r < NrReq; r++) begin
            if (!req_valid[r] && $urandom_range(0, 2) != 0) begin
               int id;
               case ($urandom_range(0, 9))
                  0:       id = 0;
                  1:       id = 48 + $urandom_range(0, 15);
                  default: id = $urandom_range(1, 6);
               endcase
               set_req(r, ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2),
                       ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2), id);
            end
         end
         setip_ready = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                            : ($urandom_range(0, 3) == 0);
         if (n == 400) rst = 1'b1;
         step();
         rst = 1'b0;
         for (int r = 0; r < NrReq; r++) if (acc_vec[r]) req_valid[r] = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
